// File: rtl/fpadd_arbiter.sv
// Round-robin arbiter that shares one multi-cycle single-precision fpadd among N_REQ
// requesters, one operation in flight, with a watchdog that turns a hung add into an error.
`timescale 1ns/1ps
module fpadd_arbiter #(
  parameter int N_REQ       = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [32*N_REQ-1:0]  req_a,
  input  logic [32*N_REQ-1:0]  req_b,
  output logic [N_REQ-1:0]     req_ready,
  output logic [N_REQ-1:0]     resp_valid,
  input  logic [N_REQ-1:0]     resp_ready,
  output logic [31:0]          resp_sum,
  output logic                 resp_err,
  output logic                 busy,
  output logic                 fpa_start,
  output logic [31:0]          fpa_a,
  output logic [31:0]          fpa_b,
  input  logic [31:0]          fpa_sum,
  input  logic                 fpa_done
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int WD_W  = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

  state_e           state_q, state_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] owner_q, owner_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic [31:0]      a_q, a_d;
  logic [31:0]      b_q, b_d;
  logic [31:0]      sum_q, sum_d;
  logic             err_q, err_d;

  logic [PTR_W-1:0] grant;
  logic [PTR_W:0]   scan;
  logic             found;
  logic [31:0]      sel_a, sel_b;
  logic             accept;
  logic             owner_ack;

  // Scan from ptr upward with wrap; iterating k downward leaves the nearest hit in grant.
  always_comb begin
    grant = '0;
    found = 1'b0;
    scan  = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      scan = {1'b0, ptr_q} + (PTR_W+1)'(k);
      if (scan >= (PTR_W+1)'(N_REQ)) scan = scan - (PTR_W+1)'(N_REQ);
      if (req_valid[scan[PTR_W-1:0]]) begin
        grant = scan[PTR_W-1:0];
        found = 1'b1;
      end
    end
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant == PTR_W'(i)) begin
        sel_a = req_a[32*i +: 32];
        sel_b = req_b[32*i +: 32];
      end
    end
  end

  // Gated by reset so a requester never sees a transfer that the reset then discards.
  assign accept    = (state_q == S_IDLE) && found && !reset;
  assign owner_ack = (state_q == S_RESP) && resp_ready[owner_q];

  // NOTE: every _d is given its hold value before the case, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    wd_d    = wd_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          a_d     = sel_a;
          b_d     = sel_b;
          owner_d = grant;
          ptr_d   = (grant == PTR_W'(N_REQ - 1)) ? '0 : grant + 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        wd_d    = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // fpa_done is only trusted here; a level left over from the previous op is
        // cleared by the adder during ISSUE and never reaches this state.
        if (fpa_done) begin
          sum_d   = fpa_sum;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (wd_q == WD_W'(TIMEOUT_CYC - 1)) begin
          sum_d   = '0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      S_RESP: begin
        if (owner_ack) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state flops use non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      wd_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      wd_q    <= wd_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    req_ready  = '0;
    resp_valid = '0;
    if (accept) req_ready[grant] = 1'b1;
    if (state_q == S_RESP) resp_valid[owner_q] = 1'b1;
  end

  assign fpa_start = (state_q == S_ISSUE);
  assign busy      = (state_q != S_IDLE);
  assign fpa_a     = a_q;
  assign fpa_b     = b_q;
  assign resp_sum  = sum_q;
  assign resp_err  = err_q;

endmodule

// File: tb/tb_fpadd_arbiter.sv
// Directed bench for fpadd_arbiter: a stub adder with programmable latency or hang,
// hand-computed sums, and per-scenario inline comparisons.
`timescale 1ns/1ps
module tb_fpadd_arbiter;

  localparam int N_REQ       = 4;
  localparam int TIMEOUT_CYC = 64;
  localparam logic [31:0] ONE = 32'h3F800000;
  // Requester g adds float(g+1) + 1.0 in the round-robin scenario.
  localparam logic [31:0] OPA  [4] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
  localparam logic [31:0] SUMS [4] = '{32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000};

  logic                clk = 1'b0;
  logic                reset;
  logic [N_REQ-1:0]    req_valid;
  logic [32*N_REQ-1:0] req_a, req_b;
  logic [N_REQ-1:0]    req_ready;
  logic [N_REQ-1:0]    resp_valid;
  logic [N_REQ-1:0]    resp_ready;
  logic [31:0]         resp_sum;
  logic                resp_err;
  logic                busy;
  logic                fpa_start;
  logic [31:0]         fpa_a, fpa_b;
  logic [31:0]         fpa_sum;
  logic                fpa_done;

  int n_vec = 0;
  int n_err = 0;

  int stub_lat  = 2;
  bit stub_hang = 1'b0;
  bit stub_busy;
  int stub_cnt;

  always #5 clk = ~clk;

  fpadd_arbiter #(.N_REQ(N_REQ), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_sum(resp_sum), .resp_err(resp_err),
    .busy(busy), .fpa_start(fpa_start), .fpa_a(fpa_a), .fpa_b(fpa_b),
    .fpa_sum(fpa_sum), .fpa_done(fpa_done)
  );

  // Hand-computed IEEE-754 single-precision sums for the operand pairs used below.
  function automatic logic [31:0] fp_ref(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      64'h3F800000_40000000: return 32'h40400000;
      64'h3F800000_3F800000: return 32'h40000000;
      64'h40000000_3F800000: return 32'h40400000;
      64'h40400000_3F800000: return 32'h40800000;
      64'h40800000_3F800000: return 32'h40A00000;
      64'hC0A00000_40A00000: return 32'h00000000;
      default:               return 32'hDEADBEEF;
    endcase
  endfunction

  // Stub adder: done is a level that drops on the edge after start, rises stub_lat edges later.
  always @(posedge clk) begin
    if (reset) begin
      fpa_done  <= 1'b0;
      fpa_sum   <= '0;
      stub_busy <= 1'b0;
      stub_cnt  <= 0;
    end else if (fpa_start) begin
      fpa_done  <= 1'b0;
      stub_busy <= !stub_hang;
      stub_cnt  <= 0;
    end else if (stub_busy) begin
      if (stub_cnt == stub_lat - 1) begin
        fpa_done  <= 1'b1;
        fpa_sum   <= fp_ref(fpa_a, fpa_b);
        stub_busy <= 1'b0;
      end else begin
        stub_cnt <= stub_cnt + 1;
      end
    end
  end

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b);
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
    req_valid[i]      = 1'b1;
  endtask

  // Called at the negedge showing fpa_start; returns negedges until resp_valid (-1 if never)
  // and the number of cycles that broke the one-op-in-flight rules.
  task automatic wait_resp(input logic [31:0] exp_a, input logic [31:0] exp_b,
                           output int n_cyc, output int bad);
    n_cyc = -1;
    bad   = 0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (req_ready !== '0 || fpa_start !== 1'b0 || busy !== 1'b1 ||
          fpa_a !== exp_a || fpa_b !== exp_b) bad++;
      if (resp_valid !== '0) begin
        n_cyc = i;
        break;
      end
    end
  endtask

  task automatic finish_resp(input int owner);
    resp_ready = N_REQ'(1) << owner;
    @(negedge clk);
    resp_ready = '0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_vec++;
    if ({req_ready, resp_valid, busy, fpa_start, resp_err} !== '0) begin
      n_err++;
      $display("FAIL reset_ctrl: got %b, expected 0", {req_ready, resp_valid, busy, fpa_start, resp_err});
    end
    n_vec++;
    if ({fpa_a, fpa_b, resp_sum} !== '0) begin
      n_err++;
      $display("FAIL reset_data: got %h, expected 0", {fpa_a, fpa_b, resp_sum});
    end
    reset = 1'b0;
    @(negedge clk);
    n_vec++;
    if (busy !== 1'b0 || req_ready !== '0) begin
      n_err++;
      $display("FAIL reset_idle: got busy=%b ready=%b, expected 0/0", busy, req_ready);
    end
  endtask

  task automatic test_single();
    int n, bad;
    stub_lat = 3;
    set_req(0, 32'h3F800000, 32'h40000000);
    #1;
    n_vec++;
    if (req_ready !== 4'b0001) begin
      n_err++; $display("FAIL single_ready: got %b, expected 0001", req_ready);
    end
    @(negedge clk);
    n_vec++;
    if (fpa_start !== 1'b1 || fpa_a !== 32'h3F800000 || fpa_b !== 32'h40000000) begin
      n_err++; $display("FAIL single_start: got start=%b a=%h b=%h, expected 1/3f800000/40000000", fpa_start, fpa_a, fpa_b);
    end
    req_valid = '0;
    wait_resp(32'h3F800000, 32'h40000000, n, bad);
    // done rises 3 edges after the start edge and resp_valid follows one edge later.
    n_vec++;
    if (n !== 5 || bad !== 0) begin
      n_err++; $display("FAIL single_latency: got %0d cycles bad=%0d, expected 5 cycles bad=0", n, bad);
    end
    n_vec++;
    if (resp_valid !== 4'b0001 || resp_sum !== 32'h40400000 || resp_err !== 1'b0) begin
      n_err++; $display("FAIL single_resp: got v=%b sum=%h err=%b, expected 0001/40400000/0", resp_valid, resp_sum, resp_err);
    end
    finish_resp(0);
    n_vec++;
    if (resp_valid !== '0 || busy !== 1'b0) begin
      n_err++; $display("FAIL single_release: got v=%b busy=%b, expected 0/0", resp_valid, busy);
    end
  endtask

  task automatic test_round_robin();
    int n, bad, g;
    logic [N_REQ-1:0] oh;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    stub_lat = 2;
    for (int i = 0; i < N_REQ; i++) set_req(i, OPA[i], ONE);
    for (int k = 0; k < 8; k++) begin
      g  = k % N_REQ;
      oh = N_REQ'(1) << g;
      #1;
      n_vec++;
      if (req_ready !== oh) begin
        n_err++; $display("FAIL rr_grant%0d: got %b, expected %b", k, req_ready, oh);
      end
      @(negedge clk);
      wait_resp(OPA[g], ONE, n, bad);
      n_vec++;
      if (n < 0 || bad !== 0) begin
        n_err++; $display("FAIL rr_inflight%0d: got cycles=%0d bad=%0d, expected a response and bad=0", k, n, bad);
      end
      n_vec++;
      if (resp_valid !== oh || resp_sum !== SUMS[g]) begin
        n_err++; $display("FAIL rr_resp%0d: got v=%b sum=%h, expected %b/%h", k, resp_valid, resp_sum, oh, SUMS[g]);
      end
      finish_resp(g);
    end
    req_valid = '0;
  endtask

  task automatic test_timeout();
    int n, bad;
    stub_hang = 1'b1;
    set_req(1, 32'h40000000, ONE);
    #1;
    n_vec++;
    if (req_ready !== 4'b0010) begin
      n_err++; $display("FAIL to_grant: got %b, expected 0010", req_ready);
    end
    @(negedge clk);
    req_valid = '0;
    wait_resp(32'h40000000, ONE, n, bad);
    // TIMEOUT_CYC cycles in WAIT, then the error response.
    n_vec++;
    if (n !== TIMEOUT_CYC + 1 || bad !== 0) begin
      n_err++; $display("FAIL to_latency: got %0d cycles bad=%0d, expected %0d bad=0", n, bad, TIMEOUT_CYC + 1);
    end
    n_vec++;
    if (resp_valid !== 4'b0010 || resp_sum !== 32'h0 || resp_err !== 1'b1) begin
      n_err++; $display("FAIL to_resp: got v=%b sum=%h err=%b, expected 0010/00000000/1", resp_valid, resp_sum, resp_err);
    end
    finish_resp(1);
    stub_hang = 1'b0;
    stub_lat  = 2;
    set_req(2, 32'h40400000, ONE);
    #1;
    n_vec++;
    if (req_ready !== 4'b0100) begin
      n_err++; $display("FAIL to_next_grant: got %b, expected 0100", req_ready);
    end
    @(negedge clk);
    req_valid = '0;
    wait_resp(32'h40400000, ONE, n, bad);
    n_vec++;
    if (resp_valid !== 4'b0100 || resp_sum !== 32'h40800000 || resp_err !== 1'b0) begin
      n_err++; $display("FAIL to_next_resp: got v=%b sum=%h err=%b, expected 0100/40800000/0", resp_valid, resp_sum, resp_err);
    end
    finish_resp(2);
  endtask

  // Done arrives on the very cycle the watchdog expires: the sum must win.
  task automatic test_done_vs_timeout();
    int n, bad;
    stub_lat = TIMEOUT_CYC - 1;
    set_req(3, 32'h40800000, ONE);
    @(negedge clk);
    req_valid = '0;
    wait_resp(32'h40800000, ONE, n, bad);
    n_vec++;
    if (n !== TIMEOUT_CYC + 1) begin
      n_err++; $display("FAIL race_latency: got %0d cycles, expected %0d", n, TIMEOUT_CYC + 1);
    end
    n_vec++;
    if (resp_valid !== 4'b1000 || resp_sum !== 32'h40A00000 || resp_err !== 1'b0) begin
      n_err++; $display("FAIL race_resp: got v=%b sum=%h err=%b, expected 1000/40a00000/0", resp_valid, resp_sum, resp_err);
    end
    finish_resp(3);
    stub_lat = 2;
  endtask

  task automatic test_backpressure();
    int n, bad;
    set_req(0, ONE, ONE);
    #1;
    n_vec++;
    if (req_ready !== 4'b0001) begin
      n_err++; $display("FAIL bp_grant: got %b, expected 0001", req_ready);
    end
    @(negedge clk);
    req_valid = '0;
    set_req(3, 32'h40400000, ONE);
    wait_resp(ONE, ONE, n, bad);
    n_vec++;
    if (n < 0 || bad !== 0) begin
      n_err++; $display("FAIL bp_inflight: got cycles=%0d bad=%0d, expected a response and bad=0", n, bad);
    end
    resp_ready = 4'b1000;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (resp_valid !== 4'b0001 || resp_sum !== 32'h40000000 || resp_err !== 1'b0 ||
          req_ready !== '0 || fpa_start !== 1'b0) bad++;
    end
    n_vec++;
    if (bad !== 0) begin
      n_err++; $display("FAIL bp_hold: got %0d unstable cycles, expected 0", bad);
    end
    finish_resp(0);
    #1;
    n_vec++;
    if (req_ready !== 4'b1000) begin
      n_err++; $display("FAIL bp_back_to_back: got %b, expected 1000", req_ready);
    end
    @(negedge clk);
    n_vec++;
    if (fpa_start !== 1'b1 || fpa_a !== 32'h40400000) begin
      n_err++; $display("FAIL bp_start: got start=%b a=%h, expected 1/40400000", fpa_start, fpa_a);
    end
    req_valid = '0;
    wait_resp(32'h40400000, ONE, n, bad);
    n_vec++;
    if (resp_valid !== 4'b1000 || resp_sum !== 32'h40800000) begin
      n_err++; $display("FAIL bp_resp: got v=%b sum=%h, expected 1000/40800000", resp_valid, resp_sum);
    end
    finish_resp(3);
  endtask

  task automatic test_reset_mid();
    int n, bad;
    stub_hang = 1'b1;
    set_req(1, 32'h40000000, ONE);
    @(negedge clk);
    req_valid = '0;
    repeat (3) @(negedge clk);
    n_vec++;
    if (busy !== 1'b1 || resp_valid !== '0) begin
      n_err++; $display("FAIL mid_waiting: got busy=%b v=%b, expected 1/0", busy, resp_valid);
    end
    reset = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({req_ready, resp_valid, busy, fpa_start, resp_err} !== '0 || {fpa_a, fpa_b, resp_sum} !== '0) begin
      n_err++; $display("FAIL mid_reset: got ctrl=%b data=%h, expected all 0", {req_ready, resp_valid, busy, fpa_start, resp_err}, {fpa_a, fpa_b, resp_sum});
    end
    reset     = 1'b0;
    stub_hang = 1'b0;
    stub_lat  = 2;
    set_req(0, ONE, ONE);
    set_req(2, 32'h40400000, ONE);
    #1;
    n_vec++;
    if (req_ready !== 4'b0001) begin
      n_err++; $display("FAIL mid_grant: got %b, expected 0001", req_ready);
    end
    @(negedge clk);
    req_valid = '0;
    wait_resp(ONE, ONE, n, bad);
    n_vec++;
    if (resp_valid !== 4'b0001 || resp_sum !== 32'h40000000 || bad !== 0) begin
      n_err++; $display("FAIL mid_resp: got v=%b sum=%h bad=%0d, expected 0001/40000000/0", resp_valid, resp_sum, bad);
    end
    finish_resp(0);
  endtask

  // The previous op leaves done high with sum 2.0 while the next op is in ISSUE.
  task automatic test_stale_done();
    int n, bad;
    stub_lat = 4;
    set_req(1, 32'hC0A00000, 32'h40A00000);
    @(negedge clk);
    req_valid = '0;
    n_vec++;
    if (fpa_start !== 1'b1 || resp_valid !== '0) begin
      n_err++; $display("FAIL stale_issue: got start=%b v=%b, expected 1/0", fpa_start, resp_valid);
    end
    wait_resp(32'hC0A00000, 32'h40A00000, n, bad);
    n_vec++;
    if (n !== 6) begin
      n_err++; $display("FAIL stale_latency: got %0d cycles, expected 6", n);
    end
    n_vec++;
    if (resp_valid !== 4'b0010 || resp_sum !== 32'h00000000 || resp_err !== 1'b0) begin
      n_err++; $display("FAIL stale_resp: got v=%b sum=%h err=%b, expected 0010/00000000/0", resp_valid, resp_sum, resp_err);
    end
    finish_resp(1);
  endtask

  initial begin
    reset      = 1'b1;
    req_valid  = '0;
    req_a      = '0;
    req_b      = '0;
    resp_ready = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_done_vs_timeout();
    test_backpressure();
    test_reset_mid();
    test_stale_done();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not complete, expected completion");
    $fatal(1, "bench time limit reached");
  end

endmodule
